// File: rtl/toy_mips_pkg.sv
`default_nettype none
// toy_mips_pkg: shared state encoding, memory-size defaults and halt encoding
// for the toy MIPS run controller.  Rev 1.0
package toy_mips_pkg;

  localparam int unsigned IMEM_WORDS_DEF = 64;
  localparam int unsigned DMEM_WORDS_DEF = 64;
  localparam int unsigned MAX_CYCLES_DEF = 4096;
  localparam logic [31:0] HALT_WORD_DEF  = 32'h0000_003f;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_WAIT = 3'd1,
    ST_LOAD_WR   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DUMP      = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  // Big-endian byte select: k=0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/toy_mips_word_splitter.sv
`default_nettype none
// toy_mips_word_splitter: captures one instruction word and emits it as four
// consecutive big-endian byte writes.  Rev 1.0
module toy_mips_word_splitter
  import toy_mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] word_i,
  output logic        we_o,
  output logic [1:0]  byte_idx_o,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] word_q;
  logic [1:0]  k_q;
  logic        active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      k_q      <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      word_q   <= word_i;
      k_q      <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      k_q <= k_q + 2'd1;
      if (k_q == 2'd3) begin
        active_q <= 1'b0;
      end
    end
  end

  assign we_o       = active_q;
  assign byte_idx_o = active_q ? k_q : 2'd0;
  assign byte_o     = active_q ? word_byte(word_q, k_q) : 8'h00;
  assign last_o     = active_q && (k_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/toy_mips_run_ctrl.sv
`default_nettype none
// toy_mips_run_ctrl: loads a program into the core's byte-wide instruction
// memory, runs the core until halt or cycle limit, then streams out data memory.  Rev 1.0
module toy_mips_run_ctrl
  import toy_mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEF,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  input  logic [31:0]                       ld_data,
  output logic                              imem_we,
  output logic [$clog2(4*IMEM_WORDS)-1:0]   imem_addr,
  output logic [7:0]                        imem_wdata,
  output logic                              core_reset,
  input  logic [31:0]                       core_instr,
  output logic [$clog2(DMEM_WORDS)-1:0]     dmem_raddr,
  input  logic [31:0]                       dmem_rdata,
  output logic                              dump_valid,
  input  logic                              dump_ready,
  output logic [31:0]                       dump_data,
  output logic [$clog2(DMEM_WORDS)-1:0]     dump_addr,
  output logic                              dump_last,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [IW-1:0] LAST_WORD  = IW'(IMEM_WORDS - 1);
  localparam logic [DW-1:0] LAST_DUMP  = DW'(DMEM_WORDS - 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

  state_e        state_q;
  logic [IW-1:0] word_idx_q;
  logic [DW-1:0] dump_idx_q;
  logic [CW-1:0] run_cnt_q;
  logic          timeout_q;

  logic          split_load;
  logic          split_we;
  logic [1:0]    split_k;
  logic [7:0]    split_byte;
  logic          split_last;

  assign split_load = (state_q == ST_LOAD_WAIT) && ld_valid;

  toy_mips_word_splitter u_splitter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (split_load),
    .word_i     (ld_data),
    .we_o       (split_we),
    .byte_idx_o (split_k),
    .byte_o     (split_byte),
    .last_o     (split_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      dump_idx_q <= '0;
      run_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_LOAD_WAIT;
            word_idx_q <= '0;
            dump_idx_q <= '0;
            run_cnt_q  <= '0;
            timeout_q  <= 1'b0;
          end
        end
        ST_LOAD_WAIT: begin
          if (ld_valid) begin
            state_q <= ST_LOAD_WR;
          end
        end
        ST_LOAD_WR: begin
          if (split_last) begin
            if (word_idx_q == LAST_WORD) begin
              state_q <= ST_RUN;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
              state_q    <= ST_LOAD_WAIT;
            end
          end
        end
        ST_RUN: begin
          run_cnt_q <= run_cnt_q + 1'b1;
          // A halt seen on the limit cycle still counts as a clean halt.
          if (core_instr == HALT_WORD) begin
            state_q <= ST_DRAIN;
          end else if (run_cnt_q == LAST_CYCLE) begin
            state_q   <= ST_DRAIN;
            timeout_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_DUMP;
          dump_idx_q <= '0;
        end
        ST_DUMP: begin
          if (dump_ready) begin
            if (dump_idx_q == LAST_DUMP) begin
              state_q <= ST_DONE;
            end else begin
              dump_idx_q <= dump_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ld_ready   = (state_q == ST_LOAD_WAIT);
  assign imem_we    = split_we;
  assign imem_addr  = split_we ? {word_idx_q, split_k} : '0;
  assign imem_wdata = split_byte;

  assign core_reset = !((state_q == ST_RUN) || (state_q == ST_DRAIN));

  assign dump_valid = (state_q == ST_DUMP);
  assign dmem_raddr = dump_valid ? dump_idx_q : '0;
  assign dump_addr  = dump_valid ? dump_idx_q : '0;
  assign dump_data  = dump_valid ? dmem_rdata : 32'h0;
  assign dump_last  = dump_valid && (dump_idx_q == LAST_DUMP);

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done    = (state_q == ST_DONE);
  assign timeout = timeout_q;

endmodule
`default_nettype wire
